q2_alu_seq: RTL
===============

// Module: q2_alu_seq
// PURPOSE
//  Word-level sequencer that drives the Q2 bit-serial ALU slice: loads parallel operands, shifts them LSB-first
//  into the slice one bit per clock, collects the serial result and carry/zero flag back into a parallel word.
//  Sits between the register file/control unit and the 1-bit ALU; its outputs feed the slice's operand inputs.
//  Its inputs take the slice's result and carry outputs.
// PARAMETERS
//  WIDTH  12  data word width in bits (>=2); also the number of bit cycles per operation
// PORTS
//  clk        in   1      system clock; single clock domain, rising edge
//  rst        in   1      synchronous, active-high reset
//  start      in   1      request operation; accepted only when ready=1
//  ready      out  1      sequencer idle, start will be accepted
//  op         in   2      {op4,op3}: 00 pass x, 01 nor, 10 add, 11 rotate-right-through-flag
//  a_in       in   WIDTH  accumulator operand
//  x_in       in   WIDTH  second operand
//  flag_in    in   1      carry in (add) / shift-in bit (rotate); ignored for 00/01
//  alu_a0     out  1      current a bit to slice
//  alu_x0     out  1      current x bit to slice
//  alu_x1     out  1      next x bit to slice (lookahead for rotate)
//  alu_f      out  1      running flag to slice
//  alu_op3    out  1      op[0] latched at start
//  alu_op4    out  1      op[1] latched at start
//  alu_out    in   1      slice result bit
//  alu_cout   in   1      slice flag/carry bit
//  result     out  WIDTH  parallel result; held until next accepted start
//  flag_out   out  1      final flag; held with result
//  done       out  1      one-cycle pulse: result/flag_out valid
// BEHAVIOUR
//  Reset: ready=1, done=0, result=0, flag_out=0, all alu_* outputs=0, state=IDLE, bit counter=0.
//  States: IDLE -> SHIFT (start & ready) -> DONE (after bit WIDTH-1) -> IDLE (unconditionally, next cycle).
//  On accept: latch op, a_sh=a_in, x_sh=x_in, cnt=0, shin=flag_in; f=flag_in for op 10/11, f=1 for op 00/01.
//  SHIFT, cycle cnt=i: alu_a0=a_sh[0], alu_x0=x_sh[0], alu_x1 = x_sh[1] (i<WIDTH-1) or shin (i=WIDTH-1).
//   alu_f=f. At clock edge: alu_out shifted into res_sh MSB, a_sh/x_sh shifted right, cnt++.
//   f<=alu_cout (ops 00/01/10); op 11: f<=alu_cout only at i=0 (so final flag = x_in[0]).
//  Ops 00/01 therefore yield flag_out=1 iff result==0; op 10 yields carry out of MSB; op 11 yields
//  result={flag_in, x_in[WIDTH-1:1]}, flag_out=x_in[0].
//  DONE: result<=res_sh, flag_out<=f registered on entry; done=1 for exactly this cycle; ready=0.
//  Latency: start accepted at edge 0 -> done high in cycle WIDTH+1; back-to-back start accepted cycle WIDTH+2.
//  ready=1 only in IDLE. start while SHIFT or DONE is ignored (no queuing); op/a_in/x_in need only be valid
//   in the accept cycle.
//  alu_* outputs forced 0 outside SHIFT (alu_op3/op4 hold latched op).
//  rst mid-operation: abort immediately, full reset values next cycle, no done pulse, result cleared.
//  Counter width clog2(WIDTH); no wrap beyond WIDTH-1.
// CONFIGURATION
//  Q2_ALU_SEQ_ZERO_EN defined: extra output port zero (1 bit) = (result==0), registered with result.
//   Reset 0; valid for all ops regardless of flag semantics.
//  Undefined: port absent; zero detect available only via flag_out for ops 00/01.
// TESTING
//  1. op=10, a=0x0FF, x=0x001, flag_in=0 -> done in cycle 13, result=0x100, flag_out=0.
//  2. op=10, a=0xFFF, x=0x001, flag_in=0 -> result=0x000, flag_out=1; op=01, a=0x0F0, x=0x00F
//     -> result=0xF00, flag_out=0.
//  3. op=00, x=0x000 -> result=0x000, flag_out=1; op=00, x=0x400 -> result=0x400, flag_out=0.
//  4. op=11, x=0x801, flag_in=1 -> result=0xC00, flag_out=1; x=0x002, flag_in=0 -> result=0x001, flag_out=0.
//  5. start held high continuously during an operation -> single done per op; next op accepted
//     only in IDLE, inputs changed mid-op have no effect.
//  6. rst asserted at cnt=5 -> next cycle ready=1, result=0, flag_out=0, no done; new op then completes normally.

Source files
------------

// File: rtl/q2_alu_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : q2_alu_seq
// Description : Word-level sequencer for the Q2 bit-serial ALU slice. Shifts
//               operands LSB-first into the slice and gathers the result word.
//               Optional zero-detect output enabled by Q2_ALU_SEQ_ZERO_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module q2_alu_seq #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] x_in,
    input  logic             flag_in,
    output logic             alu_a0,
    output logic             alu_x0,
    output logic             alu_x1,
    output logic             alu_f,
    output logic             alu_op3,
    output logic             alu_op4,
    input  logic             alu_out,
    input  logic             alu_cout,
    output logic [WIDTH-1:0] result,
    output logic             flag_out,
`ifdef Q2_ALU_SEQ_ZERO_EN
    output logic             zero,
`endif
    output logic             done
);

    localparam int                 c_CNT_W = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [1:0]         r_op;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_x_sh;
    logic [WIDTH-1:0]   r_res_sh;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_shin;
    logic               r_f;
    logic [WIDTH-1:0]   r_result;
    logic               r_flag;
`ifdef Q2_ALU_SEQ_ZERO_EN
    logic               r_zero;
`endif

    logic               w_shift;
    logic               w_last;
    logic               w_accept;
    logic [WIDTH-1:0]   w_res_next;
    logic               w_f_next;

    assign w_shift    = (r_state == S_SHIFT);
    assign w_last     = (r_cnt == c_LAST);
    assign w_accept   = (r_state == S_IDLE) && start;
    assign w_res_next = {alu_out, r_res_sh[WIDTH-1:1]};
    // Rotate keeps only the bit shifted out at position 0 as its final flag
    assign w_f_next   = (r_op == 2'b11 && r_cnt != '0) ? r_f : alu_cout;

    assign alu_a0  = w_shift & r_a_sh[0];
    assign alu_x0  = w_shift & r_x_sh[0];
    assign alu_x1  = w_shift & (w_last ? r_shin : r_x_sh[1]);
    assign alu_f   = w_shift & r_f;
    assign alu_op3 = r_op[0];
    assign alu_op4 = r_op[1];

    assign result   = r_result;
    assign flag_out = r_flag;
`ifdef Q2_ALU_SEQ_ZERO_EN
    assign zero     = r_zero;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        ready        = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    w_state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op     <= '0;
            r_a_sh   <= '0;
            r_x_sh   <= '0;
            r_res_sh <= '0;
            r_cnt    <= '0;
            r_shin   <= 1'b0;
            r_f      <= 1'b0;
            r_result <= '0;
            r_flag   <= 1'b0;
`ifdef Q2_ALU_SEQ_ZERO_EN
            r_zero   <= 1'b0;
`endif
        end else if (w_accept) begin
            r_op   <= op;
            r_a_sh <= a_in;
            r_x_sh <= x_in;
            r_cnt  <= '0;
            r_shin <= flag_in;
            // Pass/nor run the flag as an all-zero tracker seeded with 1
            r_f    <= op[1] ? flag_in : 1'b1;
        end else if (w_shift) begin
            r_res_sh <= w_res_next;
            r_a_sh   <= r_a_sh >> 1;
            r_x_sh   <= r_x_sh >> 1;
            r_f      <= w_f_next;
            if (w_last) begin
                r_cnt    <= '0;
                r_result <= w_res_next;
                r_flag   <= w_f_next;
`ifdef Q2_ALU_SEQ_ZERO_EN
                r_zero   <= (w_res_next == '0);
`endif
            end else begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire
